// File: rtl/wb_commit_arbiter.sv
// Register-file write-port arbiter: ALU > round-robin(LSU, MDU) with per-source result FIFOs
// and a pending-write scoreboard. Define WB_BYPASS_EN to add the commit-cycle bypass ports.

module wb_commit_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (push && !flush && !full) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push && !full) wp <= wp + AW'(1);
      if (pop && !empty) rp <= rp + AW'(1);
      case ({push && !full, pop && !empty})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module wb_commit_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_we,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic            flush,
  input  logic [4:0]      chk_a,
  input  logic [4:0]      chk_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            RegWrite,
  output logic [4:0]      addD,
  output logic [XLEN-1:0] WB_out
`ifdef WB_BYPASS_EN
  ,
  output logic            byp_a_hit,
  output logic            byp_b_hit,
  output logic [XLEN-1:0] byp_data
`endif
);
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;
  localparam int RW = $bits(res_t);

  // Index 0 = LSU, index 1 = MDU throughout.
  res_t [1:0] q_in, q_head;
  logic [1:0] q_valid, q_nz, q_push, q_empty, q_full, q_gnt;
  res_t       head;
  logic       alu_gnt, from_q, last_mdu;
  logic [31:0] pending;

  assign q_in[0] = '{rd: lsu_rd, data: lsu_data};
  assign q_in[1] = '{rd: mdu_rd, data: mdu_data};
  assign q_valid = {mdu_valid, lsu_valid};
  assign q_nz    = {mdu_rd != 5'd0, lsu_rd != 5'd0};
  // rd==0 results complete the handshake but are dropped.
  assign q_push  = q_valid & ~q_full & q_nz;

  for (genvar i = 0; i < 2; i++) begin : g_q
    wb_commit_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (q_push[i]),
      .pop   (q_gnt[i]),
      .din   (q_in[i]),
      .dout  (q_head[i]),
      .empty (q_empty[i]),
      .full  (q_full[i])
    );
  end

  assign lsu_ready = ~q_full[0];
  assign mdu_ready = ~q_full[1];

  always_comb begin
    alu_gnt = alu_we && (alu_rd != 5'd0);
    q_gnt   = 2'b00;
    if (!alu_gnt && !flush) begin
      if (!q_empty[0] && !q_empty[1]) q_gnt = last_mdu ? 2'b01 : 2'b10;
      else                            q_gnt = ~q_empty;
    end
  end

  assign head = q_gnt[1] ? q_head[1] : q_head[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      addD     <= '0;
      WB_out   <= '0;
      from_q   <= 1'b0;
      last_mdu <= 1'b1;
    end else if (alu_gnt) begin
      RegWrite <= 1'b1;
      addD     <= alu_rd;
      WB_out   <= alu_data;
      from_q   <= 1'b0;
    end else if (|q_gnt) begin
      RegWrite <= 1'b1;
      addD     <= head.rd;
      WB_out   <= head.data;
      from_q   <= 1'b1;
      last_mdu <= q_gnt[1];
    end else begin
      RegWrite <= 1'b0;
      from_q   <= 1'b0;
    end
  end

  // Clear is ordered before set so a same-edge set of the same index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      if (RegWrite && from_q)               pending[addD]   <= 1'b0;
      if (iss_valid && (iss_rd != 5'd0))    pending[iss_rd] <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_a_hit = RegWrite && (addD == chk_a) && (chk_a != 5'd0);
  assign byp_b_hit = RegWrite && (addD == chk_b) && (chk_b != 5'd0);
  assign byp_data  = WB_out;
  assign busy_a    = pending[chk_a] && (chk_a != 5'd0) && !byp_a_hit;
  assign busy_b    = pending[chk_b] && (chk_b != 5'd0) && !byp_b_hit;
`else
  assign busy_a    = pending[chk_a] && (chk_a != 5'd0);
  assign busy_b    = pending[chk_b] && (chk_b != 5'd0);
`endif
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: ALU vector table, directed corner sequences, and a
// randomized run against a queue-based reference model.
module tb_wb_commit_arbiter;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_we, lsu_valid, mdu_valid, iss_valid, flush;
  logic [4:0] alu_rd, lsu_rd, mdu_rd, iss_rd, chk_a, chk_b;
  logic [XLEN-1:0] alu_data, lsu_data, mdu_data;
  logic lsu_ready, mdu_ready, busy_a, busy_b, RegWrite;
  logic [4:0] addD;
  logic [XLEN-1:0] WB_out;
`ifdef WB_BYPASS_EN
  logic byp_a_hit, byp_b_hit;
  logic [XLEN-1:0] byp_data;
`endif

  always #5 clk = ~clk;

  wb_commit_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .chk_a(chk_a), .chk_b(chk_b), .busy_a(busy_a), .busy_b(busy_b),
    .RegWrite(RegWrite), .addD(addD), .WB_out(WB_out)
`ifdef WB_BYPASS_EN
    , .byp_a_hit(byp_a_hit), .byp_b_hit(byp_b_hit), .byp_data(byp_data)
`endif
  );

  int pass_cnt = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    alu_we = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    iss_valid = 0; iss_rd = 0; flush = 0; chk_a = 0; chk_b = 0;
  endtask

  // Reference model: result queues, pending set, last queue winner, write-port register.
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t lq[$], mq[$];
  logic [31:0] m_pend;
  logic m_last_mdu, m_rw, m_fromq, l_acc, m_acc, lhold, mhold;
  logic [4:0] m_ad;
  logic [XLEN-1:0] m_wb;

  task automatic model_reset();
    lq.delete(); mq.delete();
    m_pend = 0; m_last_mdu = 1; m_rw = 0; m_fromq = 0; m_ad = 0; m_wb = 0;
    lhold = 0; mhold = 0;
  endtask

  function automatic logic m_busy(input logic [4:0] r);
    return m_pend[r] && (r != 0) && !(BYP && m_rw && m_ad == r);
  endfunction

  task automatic model_step();
    int g = 0;  // 0 none, 1 ALU, 2 LSU, 3 MDU
    bit lr, mr;
    ent_t e;
    lr = lq.size() < DEPTH;
    mr = mq.size() < DEPTH;
    if (alu_we && alu_rd != 0) g = 1;
    else if (!flush) begin
      if (lq.size() > 0 && mq.size() > 0) g = m_last_mdu ? 2 : 3;
      else if (lq.size() > 0) g = 2;
      else if (mq.size() > 0) g = 3;
    end
    if (flush) m_pend = 0;
    else begin
      if (m_rw && m_fromq) m_pend[m_ad] = 0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
    end
    m_fromq = 0;
    case (g)
      1: begin m_rw = 1; m_ad = alu_rd; m_wb = alu_data; end
      2: begin e = lq.pop_front(); m_rw = 1; m_ad = e.rd; m_wb = e.data; m_fromq = 1; m_last_mdu = 0; end
      3: begin e = mq.pop_front(); m_rw = 1; m_ad = e.rd; m_wb = e.data; m_fromq = 1; m_last_mdu = 1; end
      default: m_rw = 0;
    endcase
    l_acc = lsu_valid && lr;
    m_acc = mdu_valid && mr;
    if (flush) begin lq.delete(); mq.delete(); end
    else begin
      if (l_acc && lsu_rd != 0) lq.push_back('{lsu_rd, lsu_data});
      if (m_acc && mdu_rd != 0) mq.push_back('{mdu_rd, mdu_data});
    end
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    logic we; logic [4:0] rd; logic [31:0] data;
    logic exp_rw; logic [4:0] exp_ad; logic [31:0] exp_wb;
  } alu_vec_t;
  alu_vec_t vt[6];

  logic [4:0]  exp_ad_seq[5];
  logic [31:0] exp_wb_seq[5];

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'h1234, 1'b1, 5'd5,  32'h1234};
    vt[1] = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd5,  32'h1234};
    vt[2] = '{1'b0, 5'd9,  32'hAAAA, 1'b0, 5'd5,  32'h1234};
    vt[3] = '{1'b1, 5'd31, 32'hCAFE, 1'b1, 5'd31, 32'hCAFE};
    vt[4] = '{1'b1, 5'd1,  32'h0,    1'b1, 5'd1,  32'h0};
    vt[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd1,  32'h0};

    // Reset state and ALU-only table
    do_reset();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_addd", addD, 0);
    chk("rst_wb", WB_out, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_mdu_ready", mdu_ready, 1);
    for (int i = 0; i < 6; i++) begin
      alu_we = vt[i].we; alu_rd = vt[i].rd; alu_data = vt[i].data;
      tick();
      chk($sformatf("alu_vec%0d_rw", i), RegWrite, vt[i].exp_rw);
      chk($sformatf("alu_vec%0d_addd", i), addD, vt[i].exp_ad);
      chk($sformatf("alu_vec%0d_wb", i), WB_out, vt[i].exp_wb);
    end

    // Load commit and scoreboard
    do_reset();
    iss_valid = 1; iss_rd = 7; chk_a = 7;
    tick(); iss_valid = 0; #1;
    chk("ld_busy_set", busy_a, 1);
    tick(); lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hDEAD; #1;
    chk("ld_ready", lsu_ready, 1);
    tick(); lsu_valid = 0;
    chk("ld_c3_rw", RegWrite, 0);
    tick();
    chk("ld_c4_rw", RegWrite, 1);
    chk("ld_c4_addd", addD, 7);
    chk("ld_c4_wb", WB_out, 32'hDEAD);
    chk("ld_c4_busy", busy_a, !BYP);
    tick();
    chk("ld_c5_rw", RegWrite, 0);
    chk("ld_c5_busy", busy_a, 0);

    // Contention: ALU holds port 3 cycles, then LSU/MDU alternate
    do_reset();
    alu_we = 1; alu_rd = 1; alu_data = 32'h100;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA0;
    mdu_valid = 1; mdu_rd = 20; mdu_data = 32'hB0;
    tick();
    chk("ct_c1_addd", addD, 1);
    alu_rd = 2; alu_data = 32'h200; lsu_rd = 11; lsu_data = 32'hA1; mdu_rd = 21; mdu_data = 32'hB1;
    tick();
    chk("ct_c2_addd", addD, 2);
    alu_rd = 3; alu_data = 32'h300; lsu_valid = 0; mdu_valid = 0; #1;
    chk("ct_lsu_full", lsu_ready, 0);
    chk("ct_mdu_full", mdu_ready, 0);
    tick();
    chk("ct_c3_addd", addD, 3);
    chk("ct_c3_wb", WB_out, 32'h300);
    alu_we = 0;
    exp_ad_seq = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd21};
    exp_wb_seq = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hB1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ct_q%0d_rw", i), RegWrite, 1);
      chk($sformatf("ct_q%0d_addd", i), addD, exp_ad_seq[i]);
      chk($sformatf("ct_q%0d_wb", i), WB_out, exp_wb_seq[i]);
    end
    tick();
    chk("ct_idle_rw", RegWrite, 0);

    // Backpressure: third LSU offer held until first pop
    do_reset();
    alu_we = 1; alu_rd = 1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0;
    tick(); alu_rd = 2; lsu_rd = 13; lsu_data = 32'hC1;
    tick(); lsu_rd = 14; lsu_data = 32'hC2; #1;
    chk("bp_c2_ready", lsu_ready, 0);
    tick(); #1;
    chk("bp_c3_ready", lsu_ready, 0);
    tick(); alu_we = 0; #1;
    chk("bp_c4_ready", lsu_ready, 0);
    tick();
    chk("bp_c5_addd", addD, 12);
    chk("bp_c5_rw", RegWrite, 1);
    #1 chk("bp_c5_ready", lsu_ready, 1);
    tick(); lsu_valid = 0;
    chk("bp_c6_addd", addD, 13);
    tick();
    chk("bp_c7_addd", addD, 14);
    chk("bp_c7_wb", WB_out, 32'hC2);
    tick();
    chk("bp_c8_rw", RegWrite, 0);

    // Flush: ALU still commits, MDU entry and pending bits discarded
    do_reset();
    chk_a = 3; chk_b = 9;
    iss_valid = 1; iss_rd = 3; alu_we = 1; alu_rd = 1; alu_data = 32'h11;
    tick(); iss_rd = 9; alu_rd = 2; mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    tick(); iss_valid = 0; mdu_valid = 0; flush = 1; alu_rd = 4; alu_data = 32'h44; #1;
    chk("fl_pre_busy3", busy_a, 1);
    chk("fl_pre_busy9", busy_b, 1);
    chk("fl_pre_mdu_ready", mdu_ready, 1);
    tick(); flush = 0; alu_we = 0;
    chk("fl_alu_rw", RegWrite, 1);
    chk("fl_alu_addd", addD, 4);
    chk("fl_alu_wb", WB_out, 32'h44);
    chk("fl_busy3", busy_a, 0);
    chk("fl_busy9", busy_b, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_no_commit%0d", i), RegWrite, 0);
    end

    // Async reset while both FIFOs are full
    do_reset();
    chk_a = 8;
    alu_we = 1; alu_rd = 1; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h5;
    mdu_valid = 1; mdu_rd = 6; mdu_data = 32'h6;
    iss_valid = 1; iss_rd = 8;
    tick(); iss_valid = 0; lsu_rd = 7; mdu_rd = 8;
    tick(); lsu_valid = 0; mdu_valid = 0; #1;
    chk("rs_full_lsu", lsu_ready, 0);
    chk("rs_full_mdu", mdu_ready, 0);
    chk("rs_busy_pre", busy_a, 1);
    rst_n = 0; alu_we = 0; #1;
    chk("rs_rw", RegWrite, 0);
    chk("rs_addd", addD, 0);
    chk("rs_wb", WB_out, 0);
    chk("rs_lsu_ready", lsu_ready, 1);
    chk("rs_mdu_ready", mdu_ready, 1);
    chk("rs_busy", busy_a, 0);
    tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rs_post_rw%0d", i), RegWrite, 0);
      chk($sformatf("rs_post_ready%0d", i), lsu_ready & mdu_ready, 1);
    end

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!lhold) begin
        lsu_valid = $urandom_range(0, 1); lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      if (!mhold) begin
        mdu_valid = $urandom_range(0, 1); mdu_rd = 5'($urandom_range(0, 7)); mdu_data = $urandom;
      end
      alu_we = ($urandom_range(0, 9) < 3);
      alu_rd = 5'($urandom_range(0, 7));
      if (m_pend[alu_rd]) alu_rd = 0;
      alu_data = $urandom;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd = 5'($urandom_range(0, 7));
      if (m_pend[iss_rd]) iss_valid = 0;
      flush = ($urandom_range(0, 63) == 0);
      chk_a = 5'($urandom_range(0, 7));
      chk_b = 5'($urandom_range(0, 7));
      #1;
      chk("rnd_lsu_ready", lsu_ready, lq.size() < DEPTH);
      chk("rnd_mdu_ready", mdu_ready, mq.size() < DEPTH);
      chk("rnd_busy_a", busy_a, m_busy(chk_a));
      chk("rnd_busy_b", busy_b, m_busy(chk_b));
      model_step();
      lhold = lsu_valid && !l_acc;
      mhold = mdu_valid && !m_acc;
      tick();
      chk("rnd_rw", RegWrite, m_rw);
      if (m_rw) chk("rnd_addd", addD, m_ad);
      if (m_rw) chk("rnd_wb", WB_out, m_wb);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
